imem_port_arbiter: RTL and testbench

- Shares the single-ported, 1-cycle-latency instruction memory between two requesters:
  - Port F: core fetch unit.
  - Port D: debug/program-loader read port.
- Fetch has fixed priority. A starvation counter guarantees D a slot.
- Tracks the owner of each in-flight read and routes the response back to that owner.
- Implements fetch flush by cancelling fetch-owned responses. Sits between the frontend and the instruction memory in the testbench/SoC top.

---
 rtl/imem_arb_pkg.sv | 22 ++
 rtl/imem_starve_counter.sv | 31 +++
 rtl/imem_port_arbiter.sv | 83 ++++++++
 tb/tb_imem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and sizing helpers for the instruction-memory port arbiter.
package imem_arb_pkg;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DEBUG = 1'b1
  } owner_t;

  typedef struct packed {
    logic   vld;
    owner_t owner;
    logic   kill;
  } inflight_t;

  localparam int unsigned MAX_WAIT_DEFAULT = 8;
  localparam int unsigned WAIT_W           = $clog2(MAX_WAIT_DEFAULT + 1);

  function automatic int unsigned wait_width(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Saturating count of cycles the debug port has waited; raises force_o at the limit.
module imem_starve_counter
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i,
  input  logic grant_i,
  output logic force_o
);

  localparam int unsigned CW = wait_width(MAX_WAIT);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (req_i && !grant_i) begin
      if (cnt_q != CMAX) cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign force_o = req_i && (cnt_q >= CMAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a 1-cycle-latency instruction memory between fetch (priority) and debug,
// routing each response back to its issuer and dropping flushed fetch responses.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_grant_o,
  input  logic              f_flush_i,
  output logic              f_valid_o,
  output logic [31:0]       f_instr_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic              d_grant_o,
  output logic              d_valid_o,
  output logic [31:0]       d_data_o,
  output logic              mem_fetch_o,
  output logic              mem_invalidate_o,
  output logic [ADDR_W-1:0] mem_address_o,
  input  logic [31:0]       mem_instruction_i,
  input  logic              mem_valid_i
);

  logic              force_d;
  logic              resp_live;
  logic [ADDR_W-1:0] last_addr_q;
  inflight_t         inflight_q;

  imem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (d_req_i),
    .grant_i (d_grant_o),
    .force_o (force_d)
  );

  // Grants are gated by reset so an asserted reset zeroes every output at once.
  always_comb begin
    f_grant_o = 1'b0;
    d_grant_o = 1'b0;
    if (rst_n_i) begin
      if (force_d || (d_req_i && !f_req_i)) d_grant_o = 1'b1;
      else if (f_req_i && !f_flush_i)       f_grant_o = 1'b1;
    end
  end

  assign mem_fetch_o      = f_grant_o | d_grant_o;
  assign mem_invalidate_o = 1'b0;
  assign mem_address_o    = d_grant_o ? d_addr_i :
                            f_grant_o ? f_addr_i : last_addr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_addr_q <= '0;
      inflight_q  <= '{vld: 1'b0, owner: OWN_FETCH, kill: 1'b0};
    end else begin
      if (mem_fetch_o) last_addr_q <= mem_address_o;
      inflight_q <= '{vld:   mem_fetch_o,
                      owner: d_grant_o ? OWN_DEBUG : OWN_FETCH,
                      kill:  1'b0};
    end
  end

  assign resp_live = mem_valid_i && inflight_q.vld;
  assign f_valid_o = resp_live && (inflight_q.owner == OWN_FETCH) && !inflight_q.kill && !f_flush_i;
  assign d_valid_o = resp_live && (inflight_q.owner == OWN_DEBUG);
  assign f_instr_o = f_valid_o ? mem_instruction_i : '0;
  assign d_data_o  = d_valid_o ? mem_instruction_i : '0;

`ifdef SIMULATION
  a_no_orphan_resp : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    mem_valid_i |-> inflight_q.vld)
    else $error("imem_port_arbiter: mem_valid_i with no read in flight");
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed checks of imem_port_arbiter against a cycle-level reference model.
module tb_imem_port_arbiter;

  localparam int unsigned MW = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          f_req_i = 1'b0, f_flush_i = 1'b0, d_req_i = 1'b0;
  logic [AW-1:0] f_addr_i = '0, d_addr_i = '0;
  logic          f_grant_o, f_valid_o, d_grant_o, d_valid_o;
  logic [31:0]   f_instr_o, d_data_o;
  logic          mem_fetch_o, mem_invalidate_o, mem_valid_i;
  logic [AW-1:0] mem_address_o;
  logic [31:0]   mem_instruction_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bit          nop_fill = 1'b0;
  bit          inject = 1'b0;
  logic        mem_valid_q = 1'b0;
  logic [31:0] mem_data_q = '0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MAX_WAIT(MW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_grant_o(f_grant_o), .f_flush_i(f_flush_i),
    .f_valid_o(f_valid_o), .f_instr_o(f_instr_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_grant_o(d_grant_o),
    .d_valid_o(d_valid_o), .d_data_o(d_data_o),
    .mem_fetch_o(mem_fetch_o), .mem_invalidate_o(mem_invalidate_o), .mem_address_o(mem_address_o),
    .mem_instruction_i(mem_instruction_i), .mem_valid_i(mem_valid_i)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (nop_fill) return 32'h0000_0013;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory: one-cycle read latency, valid follows every strobe.
  always @(posedge clk) begin
    mem_valid_q <= mem_fetch_o;
    mem_data_q  <= word_of(mem_address_o);
  end
  assign mem_valid_i       = mem_valid_q | inject;
  assign mem_instruction_i = mem_data_q;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; f_req_i = 1'b1; d_req_i = 1'b1; f_addr_i = 32'h44; d_addr_i = 32'h88;
    #2;
    vectors++;
    if ({f_grant_o, d_grant_o, f_valid_o, d_valid_o, mem_fetch_o, mem_invalidate_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 000000",
               {f_grant_o, d_grant_o, f_valid_o, d_valid_o, mem_fetch_o, mem_invalidate_o});
    end
    vectors++;
    if ({mem_address_o, f_instr_o, d_data_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got addr %h fi %h dd %h want 0", mem_address_o, f_instr_o, d_data_o);
    end
    f_req_i = 1'b0; d_req_i = 1'b0;
    next_cycle();
    rst_n_i = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch_back_to_back();
    logic e_g, e_v;
    nop_fill = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_req_i = (i < 3); f_addr_i = 32'(i * 4);
      e_g = (i < 3); e_v = (i >= 1 && i <= 3);
      #2;
      vectors++;
      if ({f_grant_o, d_grant_o, mem_fetch_o} !== {e_g, 1'b0, e_g}) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d]: got %b want %b", i, {f_grant_o, d_grant_o, mem_fetch_o}, {e_g, 1'b0, e_g});
      end
      if (e_g) begin
        vectors++;
        if (mem_address_o !== 32'(i * 4)) begin
          miscompares++;
          $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_address_o, 32'(i * 4));
        end
      end
      vectors++;
      if ({f_valid_o, d_valid_o, f_instr_o} !== {e_v, 1'b0, (e_v ? 32'h13 : 32'h0)}) begin
        miscompares++;
        $display("FAIL b2b_resp[%0d]: got fv %b dv %b %h want fv %b dv 0", i, f_valid_o, d_valid_o, f_instr_o, e_v);
      end
      next_cycle();
    end
    f_req_i = 1'b0;
    nop_fill = 1'b0;
  endtask

  task automatic test_starvation();
    logic e_d;
    d_req_i = 1'b1; d_addr_i = 32'h40;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) d_req_i = 1'b0;
      f_req_i = 1'b1; f_addr_i = 32'h100 + 32'(i * 4);
      e_d = (i == 8);
      #2;
      vectors++;
      if ({f_grant_o, d_grant_o} !== {!e_d, e_d}) begin
        miscompares++;
        $display("FAIL starve_grant[%0d]: got f%b d%b want f%b d%b", i, f_grant_o, d_grant_o, !e_d, e_d);
      end
      if (e_d) begin
        vectors++;
        if (mem_address_o !== 32'h40) begin
          miscompares++;
          $display("FAIL starve_addr: got %h want 00000040", mem_address_o);
        end
      end
      if (i == 9) begin
        vectors++;
        if ({d_valid_o, f_valid_o, d_data_o} !== {2'b10, word_of(32'h40)}) begin
          miscompares++;
          $display("FAIL starve_dresp: got dv %b fv %b %h want dv 1 fv 0 %h", d_valid_o, f_valid_o, d_data_o, word_of(32'h40));
        end
      end
      next_cycle();
    end
    f_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    f_req_i = 1'b1; f_addr_i = 32'h10;
    #2;
    vectors++;
    if (f_grant_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_issue: got %b want 1", f_grant_o);
    end
    next_cycle();
    f_flush_i = 1'b1; f_addr_i = 32'h14;
    #2;
    vectors++;
    if ({f_grant_o, mem_fetch_o, f_valid_o, f_instr_o} !== '0) begin
      miscompares++;
      $display("FAIL flush_cycle: got g%b m%b v%b %h want all 0", f_grant_o, mem_fetch_o, f_valid_o, f_instr_o);
    end
    next_cycle();
    f_flush_i = 1'b0; f_addr_i = 32'h20;
    #2;
    vectors++;
    if ({f_grant_o, f_valid_o} !== 2'b10) begin
      miscompares++; $display("FAIL flush_reissue: got g%b v%b want g1 v0", f_grant_o, f_valid_o);
    end
    next_cycle();
    f_req_i = 1'b0;
    #2;
    vectors++;
    if ({f_valid_o, f_instr_o} !== {1'b1, word_of(32'h20)}) begin
      miscompares++; $display("FAIL flush_resp: got v%b %h want v1 %h", f_valid_o, f_instr_o, word_of(32'h20));
    end
    next_cycle();
  endtask

  task automatic test_flush_debug();
    d_req_i = 1'b1; d_addr_i = 32'h30;
    #2;
    vectors++;
    if (d_grant_o !== 1'b1) begin
      miscompares++; $display("FAIL flushd_issue: got %b want 1", d_grant_o);
    end
    next_cycle();
    d_req_i = 1'b0; f_flush_i = 1'b1;
    #2;
    vectors++;
    if ({d_valid_o, f_valid_o, d_data_o} !== {2'b10, word_of(32'h30)}) begin
      miscompares++;
      $display("FAIL flushd_resp: got dv%b fv%b %h want dv1 fv0 %h", d_valid_o, f_valid_o, d_data_o, word_of(32'h30));
    end
    next_cycle();
    f_flush_i = 1'b0;
  endtask

  task automatic test_debug_only();
    d_req_i = 1'b1; d_addr_i = 32'h80;
    #2;
    vectors++;
    if ({d_grant_o, f_grant_o, mem_address_o} !== {2'b10, 32'h80}) begin
      miscompares++;
      $display("FAIL donly_grant: got d%b f%b %h want d1 f0 00000080", d_grant_o, f_grant_o, mem_address_o);
    end
    next_cycle();
    d_req_i = 1'b0;
    #2;
    vectors++;
    if ({d_valid_o, f_valid_o, d_data_o} !== {2'b10, word_of(32'h80)}) begin
      miscompares++;
      $display("FAIL donly_resp: got dv%b fv%b %h want dv1 fv0 %h", d_valid_o, f_valid_o, d_data_o, word_of(32'h80));
    end
    next_cycle();
    // A fresh wait count means fetch keeps priority for the full MAX_WAIT cycles.
    d_req_i = 1'b1; d_addr_i = 32'h84; f_req_i = 1'b1;
    for (int i = 0; i < MW; i++) begin
      f_addr_i = 32'h200 + 32'(i * 4);
      #2;
      vectors++;
      if ({f_grant_o, d_grant_o} !== 2'b10) begin
        miscompares++; $display("FAIL donly_wait[%0d]: got f%b d%b want f1 d0", i, f_grant_o, d_grant_o);
      end
      next_cycle();
    end
    d_req_i = 1'b0; f_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    f_req_i = 1'b1; f_addr_i = 32'h50;
    next_cycle();
    f_addr_i = 32'h54; d_req_i = 1'b1; d_addr_i = 32'h60;
    #2;
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({f_grant_o, d_grant_o, f_valid_o, d_valid_o, mem_fetch_o, mem_address_o, f_instr_o, d_data_o} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_zero: got g%b%b v%b%b m%b %h %h %h want all 0", f_grant_o, d_grant_o,
               f_valid_o, d_valid_o, mem_fetch_o, mem_address_o, f_instr_o, d_data_o);
    end
    f_req_i = 1'b0; d_req_i = 1'b0;
    next_cycle();
    rst_n_i = 1'b1; inject = 1'b1;
    #2;
    vectors++;
    if ({f_valid_o, d_valid_o, f_instr_o, d_data_o} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_stale: got fv%b dv%b %h %h want all 0", f_valid_o, d_valid_o, f_instr_o, d_data_o);
    end
    next_cycle();
    inject = 1'b0; f_req_i = 1'b1; f_addr_i = 32'h70;
    #2;
    vectors++;
    if ({f_grant_o, f_valid_o, d_valid_o} !== 3'b100) begin
      miscompares++; $display("FAIL rstmid_regrant: got g%b fv%b dv%b want 100", f_grant_o, f_valid_o, d_valid_o);
    end
    next_cycle();
    f_req_i = 1'b0;
    #2;
    vectors++;
    if ({f_valid_o, f_instr_o} !== {1'b1, word_of(32'h70)}) begin
      miscompares++; $display("FAIL rstmid_resp: got v%b %h want v1 %h", f_valid_o, f_instr_o, word_of(32'h70));
    end
    next_cycle();
  endtask

  task automatic test_random();
    int unsigned m_wait;
    bit          m_vld, m_own_d, e_gd, e_gf, e_fv, e_dv, drop_d;
    logic [31:0] m_resp_addr, m_last, e_addr, e_fd, e_dd;
    rst_n_i = 1'b0; f_req_i = 1'b0; d_req_i = 1'b0; f_flush_i = 1'b0;
    next_cycle();
    rst_n_i = 1'b1;
    m_wait = 0; m_vld = 1'b0; m_own_d = 1'b0; m_resp_addr = '0; m_last = '0; drop_d = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (drop_d) d_req_i = 1'b0;
      if (!d_req_i) begin
        d_req_i  = ($urandom_range(0, 3) == 0);
        d_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      f_req_i   = ($urandom_range(0, 3) != 0);
      f_addr_i  = $urandom() & 32'hFFFF_FFFC;
      f_flush_i = ($urandom_range(0, 6) == 0);
      // Rules: debug wins if starved or fetch idle; fetch otherwise unless flushing.
      e_gd = d_req_i && (m_wait >= MW || !f_req_i);
      e_gf = !e_gd && f_req_i && !f_flush_i;
      e_addr = e_gd ? d_addr_i : (e_gf ? f_addr_i : m_last);
      e_fv = m_vld && !m_own_d && !f_flush_i;
      e_dv = m_vld && m_own_d;
      e_fd = e_fv ? word_of(m_resp_addr) : 32'h0;
      e_dd = e_dv ? word_of(m_resp_addr) : 32'h0;
      #2;
      vectors++;
      if ({f_grant_o, d_grant_o, mem_fetch_o, mem_invalidate_o} !== {e_gf, e_gd, e_gf | e_gd, 1'b0}) begin
        miscompares++;
        $display("FAIL rnd_grant[%0d]: got %b want %b", n, {f_grant_o, d_grant_o, mem_fetch_o, mem_invalidate_o},
                 {e_gf, e_gd, e_gf | e_gd, 1'b0});
      end
      vectors++;
      if (mem_address_o !== e_addr) begin
        miscompares++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, mem_address_o, e_addr);
      end
      vectors++;
      if ({f_valid_o, d_valid_o, f_instr_o, d_data_o} !== {e_fv, e_dv, e_fd, e_dd}) begin
        miscompares++;
        $display("FAIL rnd_resp[%0d]: got fv%b dv%b %h %h want fv%b dv%b %h %h", n, f_valid_o, d_valid_o,
                 f_instr_o, d_data_o, e_fv, e_dv, e_fd, e_dd);
      end
      m_wait = (d_req_i && !e_gd) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      m_vld = e_gd | e_gf;
      m_own_d = e_gd;
      if (e_gd | e_gf) begin
        m_resp_addr = e_addr;
        m_last = e_addr;
      end
      drop_d = e_gd;
      next_cycle();
    end
    f_req_i = 1'b0; d_req_i = 1'b0; f_flush_i = 1'b0;
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_fetch_back_to_back();
    test_starvation();
    test_flush();
    test_flush_debug();
    test_debug_only();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
